// File: rtl/queue_drain_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// queue_sched_pkg
// Shared types and helpers for the queue drain scheduler:
//   sched_state_e : scheduler FSM state encoding (2 bits)
//   DROP_CNT_W    : width of the saturating aborted-dequeue counter
//   next_idx()    : modular increment that does not assume a power-of-two range
// -----------------------------------------------------------------------------
package queue_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } sched_state_e;

  localparam int DROP_CNT_W = 8;

  // Wrap is an explicit compare against n-1 so non-power-of-two n works.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/queue_drain_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority encoder: returns the first asserted request
// found searching upward from ptr_i, wrapping modulo NUM_Q.
//   req_i       : per-queue request (non-empty) flags
//   ptr_i       : index with highest priority this cycle
//   grant_idx_o : winning index (0 when no request)
//   grant_vld_o : high when any request is asserted
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_Q = 4,
  parameter int IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic [NUM_Q-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  int cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = 0;
    // Walk offsets from farthest to nearest; the nearest hit is written last
    // and therefore wins.
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_Q) cand = cand - NUM_Q;
      if (req_i[IDX_W'(cand)]) begin
        grant_idx_o = IDX_W'(cand);
        grant_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_drain_scheduler.sv
// -----------------------------------------------------------------------------
// queue_drain_scheduler
// Round-robin drain of NUM_Q registered-read queues into one tagged stream,
// with a per-queue burst limit.
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   enable       : gates the start of new transactions only
//   q_empty      : per-queue empty flags
//   q_data       : per-queue data_out, queue i at [i*WIDTH +: WIDTH]
//   q_deq        : one-hot dequeue strobe
//   out_valid    : out_data/out_src valid; held until out_ready
//   out_ready    : consumer accept
//   out_data     : captured word
//   out_src      : source queue index of out_data
//   busy         : FSM not idle
//   drop_cnt     : saturating count of dequeues aborted by an empty queue
// -----------------------------------------------------------------------------
module queue_drain_scheduler
  import queue_sched_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NUM_Q = 4,
  parameter  int BURST = 2,
  localparam int IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_Q-1:0]       q_empty,
  input  logic [NUM_Q*WIDTH-1:0] q_data,
  output logic [NUM_Q-1:0]       q_deq,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_src,
  output logic                   busy,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  localparam int BCNT_W = $clog2(BURST + 1);

  sched_state_e          state_q;
  logic [IDX_W-1:0]      sel_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [BCNT_W-1:0]     burst_cnt_q;
  logic [WIDTH-1:0]      out_data_q;
  logic [IDX_W-1:0]      out_src_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic [WIDTH-1:0]      q_word [NUM_Q];

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) q_word[i] = q_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_Q (NUM_Q),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i       (~q_empty),
    .ptr_i       (rr_ptr_q),
    .grant_idx_o (pick_idx),
    .grant_vld_o (pick_vld)
  );

  // The strobe is gated by the live empty flag so an emptied queue is never
  // popped; that same condition is what the FSM counts as a drop.
  always_comb begin
    q_deq = '0;
    if (state_q == DEQ && !q_empty[sel_q]) q_deq[sel_q] = 1'b1;
  end

  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign drop_cnt  = drop_cnt_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && pick_vld) begin
            sel_q   <= pick_idx;
            state_q <= DEQ;
          end
        end
        DEQ: begin
          if (q_empty[sel_q]) begin
            // Aborted pop: rr_ptr is left alone so the same queue keeps priority.
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Registered read port: data_out reflects the pop from the last edge.
          out_data_q <= q_word[sel_q];
          out_src_q  <= sel_q;
          state_q    <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            if (enable && !q_empty[sel_q] && (int'(burst_cnt_q) + 1 < BURST)) begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
              state_q     <= DEQ;
            end else begin
              rr_ptr_q    <= IDX_W'(next_idx(int'(sel_q), NUM_Q));
              burst_cnt_q <= '0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_drain_scheduler.sv
// -----------------------------------------------------------------------------
// tb_queue_drain_scheduler
// Directed bench for queue_drain_scheduler. Two instances share one set of
// modelled queues: dut_a uses BURST=2, dut_b uses BURST=1. Only one instance is
// enabled at a time. Each queue model has a registered read port: a pop on a
// rising edge loads data_out with the head word.
// -----------------------------------------------------------------------------
module tb_queue_drain_scheduler;

  localparam int W  = 8;
  localparam int NQ = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable_a, enable_b;
  logic [NQ-1:0]   q_empty;
  logic [NQ*W-1:0] q_data;
  logic [NQ-1:0]   q_deq_a, q_deq_b;
  logic            out_valid_a, out_valid_b;
  logic            out_ready;
  logic [W-1:0]    out_data_a, out_data_b;
  logic [1:0]      out_src_a, out_src_b;
  logic            busy_a, busy_b;
  logic [7:0]      drop_a, drop_b;

  always #5 clk = ~clk;

  queue_drain_scheduler #(.WIDTH(W), .NUM_Q(NQ), .BURST(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .q_empty(q_empty),
    .q_data(q_data), .q_deq(q_deq_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_src(out_src_a),
    .busy(busy_a), .drop_cnt(drop_a)
  );

  queue_drain_scheduler #(.WIDTH(W), .NUM_Q(NQ), .BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .q_empty(q_empty),
    .q_data(q_data), .q_deq(q_deq_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_src(out_src_b),
    .busy(busy_b), .drop_cnt(drop_b)
  );

  // ---------------- queue models ----------------
  logic [W-1:0]  mem [NQ][32];
  int            wr_ptr  [NQ] = '{default: 0};
  int            rd_ptr  [NQ] = '{default: 0};
  int            deq_cnt [NQ] = '{default: 0};
  logic [W-1:0]  dout    [NQ] = '{default: '0};
  logic [NQ-1:0] force_empty;
  logic [NQ-1:0] deq_any;

  assign deq_any = q_deq_a | q_deq_b;

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (deq_any[i]) begin
        dout[i]    <= mem[i][rd_ptr[i]];
        rd_ptr[i]  <= rd_ptr[i] + 1;
        deq_cnt[i] <= deq_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      q_empty[i]      = (rd_ptr[i] == wr_ptr[i]) | force_empty[i];
      q_data[i*W +: W] = dout[i];
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int q, input logic [W-1:0] d);
    mem[q][wr_ptr[q]] = d;
    wr_ptr[q] = wr_ptr[q] + 1;
  endtask

  // Waits (bounded) for out_valid on the chosen instance, sampling at negedge.
  // With out_ready high the word is accepted on the following rising edge.
  task automatic get_word(input bit use_b, output logic [W-1:0] d,
                          output logic [1:0] s, output bit ok);
    ok = 1'b0; d = '0; s = '0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (use_b ? out_valid_b : out_valid_a) begin
        ok = 1'b1;
        d  = use_b ? out_data_b : out_data_a;
        s  = use_b ? out_src_b  : out_src_a;
      end
    end
  endtask

  task automatic wait_idle(input bit use_b);
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      done = use_b ? !busy_b : !busy_a;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         q;
    logic [7:0] data;
    logic [1:0] exp_src;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] d;
  logic [1:0] s;
  bit         ok;
  int         lat;
  int         base;
  int         seen;
  logic [7:0] exp_d2 [8];
  logic [1:0] exp_s2 [8];
  logic [7:0] exp_dw [4];
  logic [1:0] exp_sw [4];

  initial begin
    vecs[0] = '{q: 0, data: 8'h01, exp_src: 2'd0, exp_data: 8'h01};
    vecs[1] = '{q: 3, data: 8'hFE, exp_src: 2'd3, exp_data: 8'hFE};
    vecs[2] = '{q: 1, data: 8'h7F, exp_src: 2'd1, exp_data: 8'h7F};
    vecs[3] = '{q: 2, data: 8'h80, exp_src: 2'd2, exp_data: 8'h80};
    exp_d2 = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
    exp_s2 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
    exp_dw = '{8'h70, 8'h60, 8'h71, 8'h61};
    exp_sw = '{2'd3, 2'd0, 2'd3, 2'd0};

    rst_n = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
    out_ready = 1'b1; force_empty = '0;

    // Reset state
    #1;
    check("rst_valid_a", {31'd0, out_valid_a}, 32'd0);
    check("rst_busy_a",  {31'd0, busy_a},      32'd0);
    check("rst_deq_a",   {28'd0, q_deq_a},     32'd0);
    check("rst_data_a",  {24'd0, out_data_a},  32'd0);
    check("rst_src_a",   {30'd0, out_src_a},   32'd0);
    check("rst_drop_a",  {24'd0, drop_a},      32'd0);
    check("rst_busy_b",  {31'd0, busy_b},      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table: single words from each queue
    enable_a = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      push(vecs[i].q, vecs[i].data);
      get_word(1'b0, d, s, ok);
      check($sformatf("vec%0d_valid", i), {31'd0, ok}, 32'd1);
      check($sformatf("vec%0d_data", i), {24'd0, d}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_src", i), {30'd0, s}, {30'd0, vecs[i].exp_src});
      wait_idle(1'b0);
    end

    // Single queue, burst continuation, latency
    enable_a = 1'b0;
    @(negedge clk);
    base = deq_cnt[2];
    push(2, 8'hAA); push(2, 8'hBB);
    enable_a = 1'b1;
    lat = 0; ok = 1'b0;
    while (lat < 10 && !ok) begin
      @(negedge clk);
      lat++;
      ok = out_valid_a;
    end
    check("t1_latency", lat, 32'd3);
    check("t1_data0", {24'd0, out_data_a}, 32'hAA);
    check("t1_src0",  {30'd0, out_src_a},  32'd2);
    get_word(1'b0, d, s, ok);
    check("t1_data1", {23'd0, ok, d}, {23'd0, 1'b1, 8'hBB});
    check("t1_src1",  {30'd0, s}, 32'd2);
    wait_idle(1'b0);
    check("t1_deq_pulses", deq_cnt[2] - base, 32'd2);

    // Fairness with BURST=2 from a fresh rr pointer
    enable_a = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(0, 8'h10 + 8'(k));
      push(1, 8'h20 + 8'(k));
    end
    enable_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      get_word(1'b0, d, s, ok);
      check($sformatf("t2_word%0d", k), {22'd0, ok, s, d}, {22'd0, 1'b1, exp_s2[k], exp_d2[k]});
    end
    wait_idle(1'b0);

    // Back-pressure
    out_ready = 1'b0;
    push(0, 8'h31); push(0, 8'h32);
    get_word(1'b0, d, s, ok);
    check("t3_first", {22'd0, ok, s, d}, {22'd0, 1'b1, 2'd0, 8'h31});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t3_hold%0d", k), {17'd0, out_valid_a, out_data_a, out_src_a, q_deq_a},
            {17'd0, 1'b1, 8'h31, 2'd0, 4'b0000});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_next_deq", {27'd0, out_valid_a, q_deq_a}, {27'd0, 1'b0, 4'b0001});
    get_word(1'b0, d, s, ok);
    check("t3_second", {22'd0, ok, s, d}, {22'd0, 1'b1, 2'd0, 8'h32});
    wait_idle(1'b0);

    // Abort: queue reads empty during DEQ
    enable_a = 1'b0;
    @(negedge clk);
    push(1, 8'h44);
    enable_a = 1'b1;
    @(posedge clk); #1;
    check("t5_deq_before", {28'd0, q_deq_a}, 32'b0010);
    force_empty = 4'b0010;
    #1;
    check("t5_deq_gated", {28'd0, q_deq_a}, 32'd0);
    @(posedge clk); #1;
    check("t5_after", {22'd0, busy_a, out_valid_a, drop_a}, {22'd0, 1'b0, 1'b0, 8'd1});
    enable_a = 1'b0;
    force_empty = '0;
    @(negedge clk);
    enable_a = 1'b1;
    get_word(1'b0, d, s, ok);
    check("t5_word_kept", {22'd0, ok, s, d}, {22'd0, 1'b1, 2'd1, 8'h44});
    wait_idle(1'b0);
    enable_a = 1'b0;

    // Wrap-around on the BURST=1 instance
    @(negedge clk);
    push(2, 8'h50);
    enable_b = 1'b1;
    get_word(1'b1, d, s, ok);
    check("t4_setup", {22'd0, ok, s, d}, {22'd0, 1'b1, 2'd2, 8'h50});
    wait_idle(1'b1);
    enable_b = 1'b0;
    push(0, 8'h60); push(0, 8'h61);
    push(3, 8'h70); push(3, 8'h71);
    @(negedge clk);
    enable_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      get_word(1'b1, d, s, ok);
      check($sformatf("t4_grant%0d", k), {22'd0, ok, s, d}, {22'd0, 1'b1, exp_sw[k], exp_dw[k]});
    end
    wait_idle(1'b1);
    enable_b = 1'b0;
    check("t4_drop_b", {24'd0, drop_b}, 32'd0);

    // Reset while a word is held in OUT (drop_cnt_a is 1 going in)
    out_ready = 1'b0;
    @(negedge clk);
    push(1, 8'h5A);
    enable_a = 1'b1;
    get_word(1'b0, d, s, ok);
    check("t6_captured", {23'd0, ok, d}, {23'd0, 1'b1, 8'h5A});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_in_reset", {18'd0, out_valid_a, busy_a, q_deq_a, drop_a},
          {18'd0, 1'b0, 1'b0, 4'b0000, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid_a) seen++;
    end
    check("t6_no_replay", seen, 32'd0);
    push(2, 8'h66);
    get_word(1'b0, d, s, ok);
    check("t6_next_word", {22'd0, ok, s, d}, {22'd0, 1'b1, 2'd2, 8'h66});
    wait_idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
